// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM encoding, bus widths, timeout default and the round-robin pick helper.
package mem_arbiter_pkg;

  localparam int XLEN            = 32;
  localparam int STRB_W          = XLEN / 8;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CTR_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_I = 2'd1,
    ST_BUS_D = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // On contention the requester that was not served last wins.
  function automatic grant_t arb_pick(input logic i_req, input logic d_req,
                                      input grant_t last);
    grant_t g;
    if (i_req && d_req) begin
      if (last == GRANT_I) g = GRANT_D;
      else                 g = GRANT_I;
    end else if (d_req) begin
      g = GRANT_D;
    end else begin
      g = GRANT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Wait-state counter for one bus access: cleared on grant, counts stalled cycles.
// expired flags the stalled cycle whose increment brings the count to TIMEOUT.
module bus_timeout_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(TIMEOUT);
  localparam logic [CTR_W-1:0] LAST  = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CTR_W'(1);
    end
  end

  // Asserted in the stalled cycle whose increment reaches TIMEOUT, so the
  // access is abandoned after exactly TIMEOUT bus cycles.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory bus between instruction fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ready,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_err,
  input  logic              d_valid,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_ready,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);

  state_t state;
  grant_t pick;
  logic   in_bus;
  logic   start;
  logic   expired;
  logic   done;
  logic   [XLEN-1:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;
`endif

  assign in_bus    = (state == ST_BUS_I) || (state == ST_BUS_D);
  assign start     = (state == ST_IDLE) && (i_valid || d_valid);
  assign done      = in_bus && (mem_ready || expired);
  // mem_ready takes precedence over a coincident expiry.
  assign resp_data = mem_ready ? mem_rdata : '0;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick = arb_pick(i_valid, d_valid, last_grant);
`else
    if (d_valid) pick = GRANT_D;
    else         pick = GRANT_I;
`endif
  end

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .enable  (in_bus && !mem_ready),
    .expired (expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_I;
    end else if (start) begin
      last_grant <= pick;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_ready   <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ready   <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            mem_valid <= 1'b1;
            if (pick == GRANT_D) begin
              state     <= ST_BUS_D;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end else begin
              state     <= ST_BUS_I;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end
          end
        end
        ST_BUS_I: begin
          if (done) begin
            state     <= ST_RESP;
            mem_valid <= 1'b0;
            i_ready   <= 1'b1;
            i_rdata   <= resp_data;
            i_err     <= !mem_ready;
          end
        end
        ST_BUS_D: begin
          if (done) begin
            state     <= ST_RESP;
            mem_valid <= 1'b0;
            d_ready   <= 1'b1;
            d_rdata   <= resp_data;
            d_err     <= !mem_ready;
          end
        end
        ST_RESP: begin
          // Error flags are only meaningful alongside the ready pulse.
          state <= ST_IDLE;
          busy  <= 1'b0;
          i_err <= 1'b0;
          d_err <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter built with TIMEOUT=4 and a behavioural wait-state memory.
// Works with or without ARB_ROUND_ROBIN_EN; the expected grant order follows the macro.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [XLEN-1:0]   i_addr;
  logic              i_ready;
  logic [XLEN-1:0]   i_rdata;
  logic              i_err;
  logic              d_valid;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_ready;
  logic [XLEN-1:0]   d_rdata;
  logic              d_err;
  logic              mem_valid;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready = 1'b0;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int mem_mode     = 1;  // 0: never ready, 1: ready after mem_wait stalls, 2: always ready
  int mem_wait     = 0;
  int wait_cnt     = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_valid   (d_valid),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory model, updated on the falling edge so the DUT samples settled values.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = mem_word(mem_addr);
    if (mem_mode == 2) begin
      mem_ready = 1'b1;
    end else if (mem_mode == 1 && mem_valid) begin
      if (wait_cnt == mem_wait) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid = 1'b0;
    i_addr  = '0;
    d_valid = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_wstrb = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    mem_mode = 1;
    mem_wait = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    int ready_cyc, ipulses, dpulses;
    logic [XLEN-1:0] rd;
    logic er;
    do_reset();
    ready_cyc = 0; ipulses = 0; dpulses = 0; rd = 'x; er = 1'bx;
    i_addr  = 32'h0000_0100;
    i_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        tests_run++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h100, 32'h0, 4'h0}) begin
          tests_failed++;
          $display("FAIL fetch_bus: got valid=%0b addr=%h wdata=%h wstrb=%h, want 1 00000100 00000000 0",
                   mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
      end
      if (i_ready) begin
        ipulses++;
        if (ready_cyc == 0) begin
          ready_cyc = k + 1;
          rd = i_rdata;
          er = i_err;
        end
        i_valid = 1'b0;
      end
      if (d_ready) dpulses++;
    end
    tests_run++;
    if (ready_cyc !== 3) begin
      tests_failed++;
      $display("FAIL fetch_latency: i_ready in cycle %0d, want 3", ready_cyc);
    end
    tests_run++;
    if (rd !== 32'h0000_0013) begin
      tests_failed++;
      $display("FAIL fetch_rdata: got %h, want 00000013", rd);
    end
    tests_run++;
    if (er !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_err: got %b, want 0", er);
    end
    tests_run++;
    if (ipulses != 1 || dpulses != 0) begin
      tests_failed++;
      $display("FAIL fetch_pulses: i_ready=%0d d_ready=%0d, want 1 0", ipulses, dpulses);
    end
  endtask

  // Runs after test_fetch so the registers hold non-zero values going in.
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests_run++;
    if ({mem_valid, i_ready, d_ready, i_err, d_err, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, want 000000",
               {mem_valid, i_ready, d_ready, i_err, d_err, busy});
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%h, want zeros", mem_addr, mem_wdata, mem_wstrb);
    end
    tests_run++;
    if ({i_rdata, d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got i=%h d=%h, want zeros", i_rdata, d_rdata);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_store();
    int vcyc, bad, ipulses, dpulses;
    logic er;
    logic [XLEN-1:0] rd;
    do_reset();
    mem_wait = 2;
    vcyc = 0; bad = 0; ipulses = 0; dpulses = 0; er = 1'bx; rd = 'x;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'hF;
    d_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (mem_valid) begin
        vcyc++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h2000, 32'hDEAD_BEEF, 4'hF}) bad++;
      end
      if (d_ready) begin
        dpulses++;
        er = d_err;
        rd = d_rdata;
        d_valid = 1'b0;
      end
      if (i_ready) ipulses++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL store_payload: %0d bad bus cycles, want 0", bad);
    end
    tests_run++;
    if (vcyc != 3) begin
      tests_failed++;
      $display("FAIL store_valid_len: mem_valid for %0d cycles, want 3", vcyc);
    end
    tests_run++;
    if (dpulses != 1 || ipulses != 0) begin
      tests_failed++;
      $display("FAIL store_pulses: d_ready=%0d i_ready=%0d, want 1 0", dpulses, ipulses);
    end
    tests_run++;
    if ({er, rd} !== {1'b0, mem_word(32'h2000)}) begin
      tests_failed++;
      $display("FAIL store_resp: got err=%b rdata=%h, want 0 %h", er, rd, mem_word(32'h2000));
    end
  endtask

  task automatic test_back_to_back();
    int i_n, d_n, bad;
    logic [0:0] got_q[$];
    logic [0:0] exp_q[$];
    do_reset();
    i_n = 0; d_n = 0; bad = 0;
    for (int n = 0; n < 6; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_q.push_back((n % 2 == 0) ? 1'b1 : 1'b0);
`else
      exp_q.push_back((n < 3) ? 1'b1 : 1'b0);
`endif
    end
    i_addr  = 32'h0000_1000;
    d_addr  = 32'h0000_3000;
    i_valid = 1'b1;
    d_valid = 1'b1;
    for (int k = 0; k < 60 && (i_valid || d_valid); k++) begin
      tick();
      if (i_ready) begin
        got_q.push_back(1'b0);
        if (i_rdata !== mem_word(i_addr) || i_err !== 1'b0) bad++;
        i_n++;
        if (i_n == 3) i_valid = 1'b0;
        else          i_addr  = 32'h0000_1000 + 32'(4 * i_n);
      end
      if (d_ready) begin
        got_q.push_back(1'b1);
        if (d_rdata !== mem_word(d_addr) || d_err !== 1'b0) bad++;
        d_n++;
        if (d_n == 3) d_valid = 1'b0;
        else          d_addr  = 32'h0000_3000 + 32'(4 * d_n);
      end
    end
    tests_run++;
    if (got_q.size() != 6) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d completions, want 6", got_q.size());
    end
    for (int n = 0; n < 6; n++) begin
      tests_run++;
      if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
        tests_failed++;
        $display("FAIL b2b_order[%0d]: got %s, want %s", n,
                 (n >= got_q.size()) ? "none" : (got_q[n] ? "D" : "I"), exp_q[n] ? "D" : "I");
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL b2b_rdata: %0d bad responses, want 0", bad);
    end
  endtask

  task automatic test_timeout();
    int vcyc, dpulses, ready_k;
    logic er;
    logic [XLEN-1:0] rd;
    logic idle_after;
    do_reset();
    mem_mode = 0;
    vcyc = 0; dpulses = 0; ready_k = 0; er = 1'bx; rd = 'x; idle_after = 1'bx;
    d_addr  = 32'h0000_4000;
    d_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (mem_valid) vcyc++;
      if (ready_k != 0 && k == ready_k + 1) idle_after = !busy && !mem_valid;
      if (d_ready) begin
        dpulses++;
        ready_k = k;
        er = d_err;
        rd = d_rdata;
        d_valid = 1'b0;
      end
    end
    mem_mode = 1;
    tests_run++;
    if (vcyc != TO) begin
      tests_failed++;
      $display("FAIL timeout_valid_len: mem_valid for %0d cycles, want %0d", vcyc, TO);
    end
    tests_run++;
    if (dpulses != 1) begin
      tests_failed++;
      $display("FAIL timeout_pulses: d_ready=%0d, want 1", dpulses);
    end
    tests_run++;
    if (er !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_err: got %b, want 1", er);
    end
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_rdata: got %h, want 00000000", rd);
    end
    tests_run++;
    if (idle_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_idle: got %b, want 1", idle_after);
    end
  endtask

  task automatic test_expiry_race();
    int vcyc, ipulses;
    logic er;
    logic [XLEN-1:0] rd;
    do_reset();
    mem_wait = TO - 1;
    vcyc = 0; ipulses = 0; er = 1'bx; rd = 'x;
    i_addr  = 32'h0000_5000;
    i_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (mem_valid) vcyc++;
      if (i_ready) begin
        ipulses++;
        er = i_err;
        rd = i_rdata;
        i_valid = 1'b0;
      end
    end
    tests_run++;
    if (vcyc != TO || ipulses != 1) begin
      tests_failed++;
      $display("FAIL race_timing: mem_valid %0d cycles, %0d pulses, want %0d 1", vcyc, ipulses, TO);
    end
    tests_run++;
    if (er !== 1'b0) begin
      tests_failed++;
      $display("FAIL race_err: got %b, want 0", er);
    end
    tests_run++;
    if (rd !== mem_word(32'h5000)) begin
      tests_failed++;
      $display("FAIL race_rdata: got %h, want %h", rd, mem_word(32'h5000));
    end
  endtask

  task automatic test_reset_mid();
    int ipulses, vcyc;
    do_reset();
    mem_mode = 0;
    i_addr  = 32'h0000_6000;
    i_valid = 1'b1;
    tick();
    tick();
    tests_run++;
    if (mem_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: mem_valid=%b, want 1", mem_valid);
    end
    reset   = 1'b1;
    i_valid = 1'b0;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({mem_valid, busy, i_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midreset_after: valid=%b busy=%b i_ready=%b, want 000", mem_valid, busy, i_ready);
    end
    mem_mode = 1;
    ipulses = 0; vcyc = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (i_ready || d_ready) ipulses++;
      if (mem_valid) vcyc++;
    end
    tests_run++;
    if (ipulses != 0 || vcyc != 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: %0d ready pulses, %0d valid cycles, want 0 0", ipulses, vcyc);
    end
  endtask

  task automatic test_ready_idle();
    int events;
    do_reset();
    mem_mode = 2;
    events = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (i_ready || d_ready || busy || mem_valid) events++;
    end
    mem_mode = 1;
    tests_run++;
    if (events != 0) begin
      tests_failed++;
      $display("FAIL idle_ready_ignored: %0d active cycles, want 0", events);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_fetch();
    test_reset();
    test_store();
    test_back_to_back();
    test_timeout();
    test_expiry_race();
    test_reset_mid();
    test_ready_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted access waits for mem_ready before erroring; range 1..65535.
REQ-002 Ports, in order (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction-fetch request.
- i_addr  in  32  fetch address.
- i_ready  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetch data, valid with i_ready.
- i_err  out  1  fetch bus error, valid with i_ready.
- d_valid  in  1  load/store request.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte write strobes; 0 = load.
- d_ready  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load data, valid with d_ready.
- d_err  out  1  data bus error, valid with d_ready.
- mem_valid  out  1  shared bus request.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus store data.
- mem_wstrb  out  4  bus strobes.
- mem_ready  in  1  bus completion.
- mem_rdata  in  32  bus read data.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 FSM states: IDLE, BUS_I, BUS_D, RESP; a single access is outstanding at any time.
REQ-004 IDLE: if only i_valid, go BUS_I; if only d_valid, go BUS_D; if both, apply REQ-012; else stay IDLE.
REQ-005 On leaving IDLE, the winning requester's addr/wdata/wstrb are registered (fetch: wdata=0, wstrb=0); mem_valid is high from the next cycle.
REQ-006 BUS_x: mem_valid and registered payload stay constant until mem_ready or timeout.
REQ-007 mem_ready high in BUS_x: register mem_rdata, clear err, go RESP; mem_valid low in RESP.
REQ-008 Timeout: wait counter clears on grant, increments each BUS_x cycle with mem_ready low; when it reaches TIMEOUT, go RESP with err=1, rdata=0, mem_valid dropped.
REQ-009 mem_ready and counter==TIMEOUT in the same cycle: mem_ready wins, err=0.
REQ-010 RESP lasts exactly one cycle: assert ready/rdata/err of the granted requester only, then go IDLE. A requester must hold valid and payload stable until its ready pulse; valid seen in the cycle after RESP is a new request.
REQ-011 Latency: request sampled in IDLE at cycle N gives mem_valid at N+1; mem_ready at cycle M gives requester ready at M+1; zero-wait-state memory yields 3 cycles valid-to-ready.
REQ-012 Both valid in IDLE: without ARB_ROUND_ROBIN_EN, data wins. With it, see REQ-016.
REQ-013 mem_ready outside BUS_x is ignored.

Reset
REQ-014 reset high: state=IDLE; mem_valid, i_ready, d_ready, i_err, d_err and busy = 0; mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata = 0; wait counter = 0; last_grant = I.
REQ-015 reset mid-access abandons the transaction with no ready pulse to either requester; mem_valid is low in the cycle after reset is sampled.

Configuration
REQ-016 Macro ARB_ROUND_ROBIN_EN defined: a registered last_grant records the requester served last. When both are valid, the grant goes to the requester opposite last_grant, so data goes first after reset. Macro undefined: fixed data priority and no last_grant register.

Structure
REQ-017 The shared package holds the FSM state encoding (2-bit), XLEN=32, the strobe width, and the TIMEOUT default.
REQ-018 One sub-module, bus_timeout_ctr: clear, enable, expired output, 16-bit counter, parameter TIMEOUT.

Verification
REQ-019 Fetch only: i_addr=0x100, mem_ready at the 1st bus cycle with rdata=0x00000013 -> i_ready pulse 3 cycles after i_valid, i_rdata=0x00000013, i_err=0.
REQ-020 Store: d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_* carry these exact values until mem_ready; d_ready for 1 cycle; i_ready stays 0.
REQ-021 Both valid, fixed priority, 3 back-to-back pairs -> all data accesses complete first; with ARB_ROUND_ROBIN_EN -> order D,I,D,I,D,I.
REQ-022 TIMEOUT=4, mem_ready held low -> mem_valid high exactly 4 cycles, then d_ready=1, d_err=1, d_rdata=0, and the FSM returns to IDLE.
REQ-023 mem_ready in the same cycle as expiry -> err=0 and rdata captured. reset during BUS_I -> no i_ready pulse, mem_valid=0 next cycle, busy=0.
